// File: rtl/mmio_uart_tx_if.sv
// ============================================================================
// Module      : mmio_uart_tx_if
// Description : CPU data-bus signals seen by the memory-mapped UART
//               transmitter: address, read/write enables, write data, read
//               data and the window-select flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_uart_tx_if;
    logic [31:0] AddressBus;
    logic        MemReadEn;
    logic        MemWriteEn;
    logic [31:0] DataMemoryInput;
    logic [31:0] DataMemoryOutput;
    logic        Sel;

    // CPU side drives address/control/write data
    modport master (
        output AddressBus, MemReadEn, MemWriteEn, DataMemoryInput,
        input  DataMemoryOutput, Sel
    );

    // Peripheral side answers with read data and select
    modport slave (
        input  AddressBus, MemReadEn, MemWriteEn, DataMemoryInput,
        output DataMemoryOutput, Sel
    );
endinterface

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. CPU writes bytes to TXDATA,
//               they are queued in a TX FIFO and sent 8N1 (LSB first) on tx.
//               STATUS and CLKDIV are readable; reads are combinational.
//               Optional macro MMIO_UART_PARITY_EN adds an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
    input  logic          clock,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
`ifdef MMIO_UART_PARITY_EN
    localparam logic       PAR_FLAG = 1'b1;
`else
    localparam logic       PAR_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [15:0]            clkdiv;
    logic [15:0]            bit_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
`ifdef MMIO_UART_PARITY_EN
    logic                   par_bit;
`endif
    logic                   overflow;
    logic [7:0]             mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [4:0]             count;

    logic                   sel, wr_en;
    logic [1:0]             offset;
    logic                   push_req, push_ok, pop;
    logic                   full, empty, busy, bit_done;
    logic [31:0]            rdata;
    logic                   unused_bits;

    // Address decode; low two address bits and upper data bits are don't-care
    assign sel         = (bus.AddressBus[31:4] == BASE_ADDR[31:4]);
    assign offset      = bus.AddressBus[3:2];
    assign wr_en       = sel && bus.MemWriteEn;
    assign push_req    = wr_en && (offset == 2'd0);
    assign unused_bits = ^{bus.AddressBus[1:0], bus.DataMemoryInput[31:16]};

    assign full     = (count == DEPTH_C);
    assign empty    = (count == 5'd0);
    assign busy     = (state != IDLE);
    assign bit_done = (bit_cnt == 16'd0);
    // A full FIFO still takes a byte when the head leaves at the same edge
    assign push_ok  = push_req && (!full || pop);

    // Register read mux; read has no side effects
    always_comb begin
        rdata = 32'd0;
        case (offset)
            2'd1:    rdata = {22'd0, PAR_FLAG, count, overflow, empty, full, busy};
            2'd2:    rdata = {16'd0, clkdiv};
            default: rdata = 32'd0;
        endcase
    end

    assign bus.Sel              = sel;
    assign bus.DataMemoryOutput = (sel && bus.MemReadEn) ? rdata : 32'd0;

    // Next-state decode; pops happen when a new frame is launched
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef MMIO_UART_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: if (bit_done) state_next = STOP;
`endif
            STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial line decoded from the registered state so it is 1 during reset
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
`ifdef MMIO_UART_PARITY_EN
            PARITY:  tx = par_bit;
`endif
            default: tx = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bit timer, bit index and shift register; CLKDIV sampled on each reload
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
`ifdef MMIO_UART_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (pop) begin
                shift   <= mem[rd_ptr];
`ifdef MMIO_UART_PARITY_EN
                par_bit <= ^mem[rd_ptr];
`endif
                bit_cnt <= clkdiv;
            end else if (state != IDLE) begin
                if (bit_done) begin
                    bit_cnt <= clkdiv;
                    if (state == DATA) shift <= {1'b0, shift[7:1]};
                end else begin
                    bit_cnt <= bit_cnt - 16'd1;
                end
            end
            if (state == START)                 bit_idx <= 3'd0;
            else if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (wr_en && offset == 2'd1 && bus.DataMemoryInput[3])
                overflow <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since occupancy governs validity
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= bus.DataMemoryInput[7:0];
    end

    // Baud divisor register
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                           clkdiv <= DEFAULT_DIV;
        else if (wr_en && offset == 2'd2)  clkdiv <= bus.DataMemoryInput[15:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx. Expected
//               serial waveforms are built from the frame format; register
//               values are hand-computed. Honours MMIO_UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef MMIO_UART_PARITY_EN
    localparam int          PAR_EN = 1;
    localparam logic [31:0] ST_PAR = 32'h0000_0200;
`else
    localparam int          PAR_EN = 0;
    localparam logic [31:0] ST_PAR = 32'h0000_0000;
`endif

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic tx;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd3)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bits(input bit b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic build_frame(input logic [7:0] d, input int div);
        push_bits(1'b0, div + 1);
        for (int i = 0; i < 8; i++) push_bits(d[i], div + 1);
        if (PAR_EN != 0) push_bits(^d, div + 1);
        push_bits(1'b1, div + 1);
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        @(negedge clock);
        bus.AddressBus      = BASE | {28'd0, off, 2'b01};
        bus.DataMemoryInput = d;
        bus.MemWriteEn      = 1'b1;
        @(posedge clock);
        #1;
        bus.MemWriteEn      = 1'b0;
        bus.AddressBus      = 32'd0;
        bus.DataMemoryInput = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] off, output logic [31:0] v);
        bus.AddressBus = BASE | {28'd0, off, 2'b00};
        bus.MemReadEn  = 1'b1;
        #1;
        v = bus.DataMemoryOutput;
        bus.MemReadEn  = 1'b0;
        bus.AddressBus = 32'd0;
    endtask

    // Walk the expected queue one clock per entry, then expect an idle line
    task automatic drain(input int first, input int st_idx, input logic [31:0] st_exp);
        logic [31:0] v;
        for (int i = first; i < exp_q.size(); i++) begin
            @(posedge clock);
            #1;
            check($sformatf("tx_bit[%0d]", i), {31'd0, tx}, {31'd0, exp_q[i]});
            if (i == st_idx) begin
                read_reg(2'd1, v);
                check("status_mid", v, st_exp);
            end
        end
        @(posedge clock);
        #1;
        check("tx_idle", {31'd0, tx}, 32'd1);
        read_reg(2'd1, v);
        check("status_done", v, 32'h004 | ST_PAR);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] v;
        int          low_seen;

        bus.AddressBus      = 32'd0;
        bus.MemReadEn       = 1'b0;
        bus.MemWriteEn      = 1'b0;
        bus.DataMemoryInput = 32'd0;

        // Reset state
        #12;
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        @(negedge clock);
        rst = 1'b0;
        #1;
        read_reg(2'd1, v);  check("status_reset", v, 32'h004 | ST_PAR);
        read_reg(2'd2, v);  check("clkdiv_reset", v, 32'd3);
        read_reg(2'd0, v);  check("txdata_read0", v, 32'd0);
        read_reg(2'd3, v);  check("reserved_read0", v, 32'd0);
        bus.AddressBus = BASE | 32'h8;
        #1;
        check("sel_in_window", {31'd0, bus.Sel}, 32'd1);
        check("dout_no_read", bus.DataMemoryOutput, 32'd0);
        bus.AddressBus = 32'h0000_0808;
        bus.MemReadEn  = 1'b1;
        #1;
        check("sel_outside", {31'd0, bus.Sel}, 32'd0);
        check("dout_outside", bus.DataMemoryOutput, 32'd0);
        bus.AddressBus = BASE + 32'h10;
        #1;
        check("sel_above", {31'd0, bus.Sel}, 32'd0);
        bus.MemReadEn  = 1'b0;
        bus.AddressBus = 32'd0;

        // Single frame 0x55 at CLKDIV=3; busy/empty sampled just after launch
        build_frame(8'h55, 3);
        bus_write(2'd0, 32'h0000_0055);
        drain(0, 0, 32'h005 | ST_PAR);

        // Back-to-back frames 0xA1, 0x0F written on consecutive edges
        build_frame(8'hA1, 3);
        build_frame(8'h0F, 3);
        bus_write(2'd0, 32'h0000_00A1);
        bus_write(2'd0, 32'h0000_000F);
        check("b2b_tx0", {31'd0, tx}, {31'd0, exp_q[0]});
        read_reg(2'd1, v);
        check("b2b_count1", v, 32'h011 | ST_PAR);
        drain(1, exp_q.size() / 2, 32'h005 | ST_PAR);

        // CLKDIV changed to 1 during data bit 3 of a CLKDIV=3 frame
        push_bits(1'b0, 4);
        for (int b = 0; b < 4; b++) push_bits(v_c3(b), 4);
        for (int b = 4; b < 8; b++) push_bits(v_c3(b), 2);
        if (PAR_EN != 0) push_bits(1'b0, 2);
        push_bits(1'b1, 2);
        bus_write(2'd0, 32'h0000_00C3);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clock);
            #1;
            if (i == 18) begin
                bus.MemWriteEn = 1'b0;
                bus.AddressBus = 32'd0;
                bus.DataMemoryInput = 32'd0;
            end
            check($sformatf("div_chg_bit[%0d]", i), {31'd0, tx}, {31'd0, exp_q[i]});
            if (i == 17) begin
                bus.AddressBus      = BASE | 32'h8;
                bus.DataMemoryInput = 32'd1;
                bus.MemWriteEn      = 1'b1;
            end
        end
        exp_q.delete();
        @(posedge clock);
        #1;
        check("div_chg_idle", {31'd0, tx}, 32'd1);

        // Simultaneous read+write of CLKDIV: read shows the pre-edge value
        @(negedge clock);
        bus.AddressBus      = BASE | 32'h8;
        bus.DataMemoryInput = 32'd0;
        bus.MemReadEn       = 1'b1;
        bus.MemWriteEn      = 1'b1;
        #1;
        check("rw_pre_edge", bus.DataMemoryOutput, 32'd1);
        @(posedge clock);
        #1;
        check("rw_post_edge", bus.DataMemoryOutput, 32'd0);
        bus.MemReadEn  = 1'b0;
        bus.MemWriteEn = 1'b0;
        bus.AddressBus = 32'd0;

        // CLKDIV=0: one clock per bit; 0x07 exercises parity=1 when enabled
        build_frame(8'h96, 0);
        bus_write(2'd0, 32'h0000_0096);
        drain(0, -1, 32'd0);
        build_frame(8'h07, 0);
        bus_write(2'd0, 32'h0000_0007);
        drain(0, -1, 32'd0);

        // FIFO fill and overflow at CLKDIV=100
        bus_write(2'd2, 32'd100);
        for (int b = 0; b < 9; b++) bus_write(2'd0, 32'h10 + b);
        read_reg(2'd1, v);  check("status_full", v, 32'h083 | ST_PAR);
        bus_write(2'd0, 32'h0000_00EE);
        read_reg(2'd1, v);  check("status_ovf", v, 32'h08B | ST_PAR);
        bus_write(2'd1, 32'h0000_0007);
        read_reg(2'd1, v);  check("ovf_not_cleared", v, 32'h08B | ST_PAR);
        bus_write(2'd1, 32'h0000_0008);
        read_reg(2'd1, v);  check("ovf_cleared", v, 32'h083 | ST_PAR);

        // Reset discards the queue and restores CLKDIV
        @(negedge clock);
        rst = 1'b1;
        #2;
        check("tx_rst_full", {31'd0, tx}, 32'd1);
        @(negedge clock);
        rst = 1'b0;
        #1;
        read_reg(2'd1, v);  check("status_after_rst", v, 32'h004 | ST_PAR);
        read_reg(2'd2, v);  check("clkdiv_after_rst", v, 32'd3);

        // Asynchronous reset during data bit 5 of 0x00
        bus_write(2'd0, 32'h0000_0000);
        for (int i = 0; i <= 25; i++) begin
            @(posedge clock);
            #1;
        end
        check("tx_bit5_low", {31'd0, tx}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("tx_async_rst", {31'd0, tx}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        read_reg(2'd1, v);  check("status_post_rst", v, 32'h004 | ST_PAR);
        low_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1) low_seen++;
        end
        check("no_resume", low_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bits of 0xC3 for the divisor-change frame
    function automatic bit v_c3(input int b);
        logic [7:0] d;
        d = 8'hC3;
        return d[b];
    endfunction

endmodule

`default_nettype wire
